// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared screen geometry constants and block-op engine state encoding
package term_pkg;

  localparam int SCREEN_COLS = 80;
  localparam int SCREEN_ROWS = 25;
  localparam int CELL_ADDR_W = 11;
  localparam int CELL_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } eng_state_t;

endpackage

// File: rtl/screen_op_engine.sv
// rtl/screen_op_engine.sv - block fill/copy engine; copy mode present only with SCREEN_SCHED_COPY_EN
module screen_op_engine
  import term_pkg::*;
#(
  parameter int ADDR_W = CELL_ADDR_W,
  parameter int DATA_W = CELL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_start,
  input  logic [ADDR_W-1:0] op_begin,
  input  logic [ADDR_W-1:0] op_end,
  input  logic [DATA_W-1:0] op_data,
  input  logic [ADDR_W-1:0] op_offset,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              grant,
  output logic              eng_req,
  output logic [ADDR_W-1:0] eng_addr,
  output logic              eng_we,
  output logic [DATA_W-1:0] eng_wdata,
  output logic              op_busy,
  output logic              op_done
);

  eng_state_t        r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] w_cur_next;
  logic              w_last;

`ifdef SCREEN_SCHED_COPY_EN
  logic [ADDR_W-1:0] r_offset;
  logic [DATA_W-1:0] r_hold;
  logic              r_first_wr;
`else
  // Fill-only build: the copy offset and read data have no consumer here.
  logic              w_unused;
  assign w_unused = ^{op_offset, ram_rdata};
`endif

  assign w_cur_next = r_cur + 1'b1;
  assign w_last     = (w_cur_next == r_end);
  assign op_busy    = (r_state != ST_IDLE);

  // Engine FSM: latches the op, walks cur upward, pulses op_done on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_end      <= '0;
      r_data     <= '0;
      op_done    <= 1'b0;
`ifdef SCREEN_SCHED_COPY_EN
      r_offset   <= '0;
      r_hold     <= '0;
      r_first_wr <= 1'b0;
`endif
    end else begin
      op_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_start) begin
            r_cur  <= op_begin;
            r_end  <= op_end;
            r_data <= op_data;
`ifdef SCREEN_SCHED_COPY_EN
            r_offset <= op_offset;
`endif
            if (op_begin >= op_end) begin
              r_state <= ST_DONE;
              op_done <= 1'b1;
            end
`ifdef SCREEN_SCHED_COPY_EN
            else if (op_offset != '0) begin
              r_state <= ST_RD;
            end
`endif
            else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (grant) begin
            r_cur <= w_cur_next;
            if (w_last) begin
              r_state <= ST_DONE;
              op_done <= 1'b1;
            end
          end
        end
`ifdef SCREEN_SCHED_COPY_EN
        ST_RD: begin
          if (grant) begin
            r_state    <= ST_WR;
            r_first_wr <= 1'b1;
          end
        end
        ST_WR: begin
          // Read data is only valid in the first WR cycle; keep it for stalled writes.
          if (r_first_wr) begin
            r_hold     <= ram_rdata;
            r_first_wr <= 1'b0;
          end
          if (grant) begin
            r_cur <= w_cur_next;
            if (w_last) begin
              r_state <= ST_DONE;
              op_done <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM request presented to the arbiter for the current state.
  always_comb begin
    eng_req   = 1'b0;
    eng_addr  = r_cur;
    eng_we    = 1'b0;
    eng_wdata = r_data;
    case (r_state)
      ST_FILL: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
      end
`ifdef SCREEN_SCHED_COPY_EN
      ST_RD: begin
        eng_req  = 1'b1;
        eng_addr = r_cur + r_offset;
      end
      ST_WR: begin
        eng_req   = 1'b1;
        eng_we    = 1'b1;
        eng_wdata = r_first_wr ? ram_rdata : r_hold;
      end
`endif
      default: begin
        eng_req = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/screen_ram_sched.sv
// rtl/screen_ram_sched.sv - character RAM port arbiter (VGA > engine > single write); copy mode via SCREEN_SCHED_COPY_EN
module screen_ram_sched
  import term_pkg::*;
#(
  parameter int ADDR_W = CELL_ADDR_W,
  parameter int DATA_W = CELL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_wdata,
  output logic              wr_ready,
  input  logic              op_start,
  input  logic [ADDR_W-1:0] op_begin,
  input  logic [ADDR_W-1:0] op_end,
  input  logic [DATA_W-1:0] op_data,
  input  logic [ADDR_W-1:0] op_offset,
  output logic              op_busy,
  output logic              op_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              w_eng_req;
  logic              w_eng_we;
  logic              w_eng_grant;
  logic [ADDR_W-1:0] w_eng_addr;
  logic [DATA_W-1:0] w_eng_wdata;
  logic [ADDR_W-1:0] r_last_addr;

  // VGA always wins; single writes wait out the whole op to keep ordering with scroll/clear.
  assign w_eng_grant = w_eng_req & ~vga_req;
  assign wr_ready    = wr_valid & ~vga_req & ~op_busy;
  assign vga_rdata   = ram_rdata;

  screen_op_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_start  (op_start),
    .op_begin  (op_begin),
    .op_end    (op_end),
    .op_data   (op_data),
    .op_offset (op_offset),
    .ram_rdata (ram_rdata),
    .grant     (w_eng_grant),
    .eng_req   (w_eng_req),
    .eng_addr  (w_eng_addr),
    .eng_we    (w_eng_we),
    .eng_wdata (w_eng_wdata),
    .op_busy   (op_busy),
    .op_done   (op_done)
  );

  // Per-cycle priority mux onto the RAM port; address parks on its last value when idle.
  always_comb begin
    ram_addr  = r_last_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vga_req) begin
      ram_addr = vga_addr;
    end else if (w_eng_req) begin
      ram_addr  = w_eng_addr;
      ram_we    = w_eng_we;
      ram_wdata = w_eng_wdata;
    end else if (wr_ready) begin
      ram_addr  = wr_addr;
      ram_we    = 1'b1;
      ram_wdata = wr_wdata;
    end
  end

  // Remember the driven address so an idle cycle holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
    end else begin
      r_last_addr <= ram_addr;
    end
  end

endmodule

// File: tb/tb_screen_ram_sched.sv
// tb/tb_screen_ram_sched.sv - self-checking bench for screen_ram_sched with a behavioural RAM
module tb_screen_ram_sched;

`ifdef SCREEN_SCHED_COPY_EN
  localparam bit COPY = 1'b1;
`else
  localparam bit COPY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        vga_req;
  logic [10:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        wr_valid;
  logic [10:0] wr_addr;
  logic [7:0]  wr_wdata;
  logic        wr_ready;
  logic        op_start;
  logic [10:0] op_begin;
  logic [10:0] op_end;
  logic [7:0]  op_data;
  logic [10:0] op_offset;
  logic        op_busy;
  logic        op_done;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem     [2048];
  logic [7:0]  exp_mem [2048];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    b;
    int    e;
    int    data;
    int    off;
    bit    vga_alt;
    bit    preload;
    int    exp_done;
    string name;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[6];

  screen_ram_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_rdata (vga_rdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_wdata  (wr_wdata),
    .wr_ready  (wr_ready),
    .op_start  (op_start),
    .op_begin  (op_begin),
    .op_end    (op_end),
    .op_data   (op_data),
    .op_offset (op_offset),
    .op_busy   (op_busy),
    .op_done   (op_done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int cyc);
    sb_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("vga_rdata", 32'(vga_rdata), 32'(e.data));
    end
  endtask

  task automatic check_contents(input string name);
    int diffs = 0;
    for (int a = 0; a < 2048; a++) if (mem[a] !== exp_mem[a]) diffs++;
    chk(name, diffs, 0);
  endtask

  task automatic preload();
    for (int a = 0; a < 2048; a++) begin
      mem[a]     <= 8'(a);
      exp_mem[a] = 8'(a);
    end
  endtask

  task automatic model_op(input vec_t v);
    for (int a = v.b; a < v.e; a++) begin
      if (COPY && v.off != 0) exp_mem[a] = exp_mem[(a + v.off) % 2048];
      else exp_mem[a] = 8'(v.data);
    end
  endtask

  task automatic run_op(input vec_t v, output int done_cyc, output int we_cnt);
    int cyc;
    sb_t s;
    @(posedge clk); #1;
    op_start  = 1'b1;
    op_begin  = 11'(v.b);
    op_end    = 11'(v.e);
    op_data   = 8'(v.data);
    op_offset = 11'(v.off);
    vga_req   = 1'b0;
    cyc = 0;
    done_cyc = -1;
    we_cnt = 0;
    while (cyc < 5000 && done_cyc < 0) begin
      @(negedge clk);
      sb_pop(cyc);
      if (vga_req) chk("vga_route", {20'd0, ram_we, ram_addr}, {20'd0, 1'b0, vga_addr});
      if (ram_we) we_cnt++;
      if (op_done) done_cyc = cyc;
      @(posedge clk); #1;
      op_start = 1'b0;
      cyc++;
      if (v.vga_alt && cyc[0]) begin
        vga_req  = 1'b1;
        vga_addr = 11'(1000 + cyc);
        s.due  = cyc + 1;
        s.data = exp_mem[1000 + cyc];
        sbq.push_back(s);
      end else begin
        vga_req = 1'b0;
      end
    end
    @(negedge clk);
    sb_pop(cyc);
    @(posedge clk); #1;
    vga_req = 1'b0;
  endtask

  initial begin
    int done_cyc;
    int we_cnt;
    int viol;
    int dn;
    vec_t v;

    rst_n = 1'b0; vga_req = 1'b0; vga_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_wdata = '0; op_start = 1'b0; op_begin = '0; op_end = '0; op_data = '0; op_offset = '0;
    for (int a = 0; a < 2048; a++) begin
      mem[a]     <= 8'h00;
      exp_mem[a] = 8'h00;
    end

    //          b     e     data   off   alt  pre  done                 name
    vecs[0] = '{0,    2000, 'h20,  0,    0,   0,   2001,                "fill_all"};
    vecs[1] = '{10,   20,   'h41,  0,    1,   1,   21,                  "fill_vga_alt"};
    vecs[2] = '{0,    1920, 'h3C,  80,   0,   1,   COPY ? 3841 : 1921,  "scroll"};
    vecs[3] = '{5,    5,    'h99,  0,    0,   0,   1,                   "degenerate"};
    vecs[4] = '{100,  110,  'h5E,  2040, 0,   1,   COPY ? 21 : 11,      "copy_wrap"};
    vecs[5] = '{30,   20,   'h77,  0,    0,   0,   1,                   "reversed"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_busy", 32'(op_busy), 0);
    chk("rst_op_done", 32'(op_done), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (v.preload) preload();
      run_op(v, done_cyc, we_cnt);
      chk({v.name, "_done_cycle"}, done_cyc, v.exp_done);
      chk({v.name, "_writes"}, we_cnt, (v.e > v.b) ? (v.e - v.b) : 0);
      model_op(v);
      check_contents({v.name, "_contents"});
      chk({v.name, "_sb_empty"}, sbq.size(), 0);
    end

    // Idle single write lands in the handshake cycle.
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 11'd100; wr_wdata = 8'h55;
    @(negedge clk);
    chk("wr_idle", {19'd0, wr_ready, ram_we, ram_addr}, {19'd0, 1'b1, 1'b1, 11'd100});
    @(posedge clk); #1;
    wr_valid = 1'b0;
    exp_mem[100] = 8'h55;
    @(negedge clk);
    chk("wr_idle_mem", 32'(mem[100]), 32'h55);

    // Collision with VGA: no handshake, no write.
    @(posedge clk); #1;
    vga_req = 1'b1; vga_addr = 11'd50; wr_valid = 1'b1; wr_wdata = 8'h66;
    @(negedge clk);
    chk("wr_vga_collide", {30'd0, wr_ready, ram_we}, 0);
    @(posedge clk); #1;
    vga_req = 1'b0; wr_valid = 1'b0; wr_wdata = 8'h55;

    // Single write held off for the whole op including the DONE cycle.
    @(posedge clk); #1;
    op_start = 1'b1; op_begin = 11'd200; op_end = 11'd210; op_data = 8'h11; op_offset = 11'd0;
    viol = 0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 11 && wr_ready) viol++;
      if (cyc == 11) chk("wrblk_done", 32'(op_done), 1);
      if (cyc == 12) chk("wr_after_done", {19'd0, wr_ready, ram_we, ram_addr}, {19'd0, 1'b1, 1'b1, 11'd100});
      @(posedge clk); #1;
      op_start = 1'b0;
      wr_valid = 1'b1;
    end
    wr_valid = 1'b0;
    chk("wrblk_ready_low", viol, 0);
    for (int a = 200; a < 210; a++) exp_mem[a] = 8'h11;
    @(negedge clk);
    check_contents("wrblk_contents");

    // Asynchronous reset mid-op aborts without op_done.
    @(posedge clk); #1;
    op_start = 1'b1; op_begin = 11'd0; op_end = 11'd100; op_data = 8'h5A; op_offset = 11'd5;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_busy", 32'(op_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(op_busy), 0);
    chk("async_rst_we", 32'(ram_we), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (op_done) dn++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (op_done) dn++;
    chk("rst_no_done", dn, 0);
    chk("rst_idle_busy", 32'(op_busy), 0);
    for (int a = 0; a < 100; a++) exp_mem[a] = mem[a];

    v = '{300, 305, 'h77, 0, 0, 0, 6, "post_rst"};
    run_op(v, done_cyc, we_cnt);
    chk("post_rst_done_cycle", done_cyc, 6);
    chk("post_rst_writes", we_cnt, 5);
    model_op(v);
    check_contents("post_rst_contents");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
